// File: rtl/atm_session_fsm.sv
// atm_session_fsm: ATM menu/session controller with PIN lockout, inactivity timeout and debug single-step
module atm_session_fsm #(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int MAX_PIN_TRIES  = 3,
  parameter int LOCK_CYCLES    = 500_000_000,
  parameter int DEBUG_STEP_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        status_valid,
  input  logic [3:0]  status_code,
  input  logic        menu_valid,
  input  logic [1:0]  menu_sel,
  input  logic        inc_state,
  output logic [3:0]  state_code,
  output logic [15:0] current_state,
  output logic [3:0]  input_style,
  output logic [3:0]  display_mode,
  output logic [3:0]  pin_tries_left,
  output logic        timeout_pulse
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [3:0] TRIES = 4'(MAX_PIN_TRIES);
  localparam logic [3:0] C_ACC_FOUND = 4'd1, C_ACC_NF = 4'd2, C_PIN_OK = 4'd3, C_PIN_BAD = 4'd4;
  localparam logic [3:0] C_AMT_OK = 4'd5, C_AMT_BAD = 4'd6, C_EXIT = 4'd7, C_DONE = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE, S_ACC_NUM, S_PIN, S_MENU, S_BAL, S_CONV_SRC, S_CONV_AMT, S_CONV_DST,
    S_WD_CUR, S_WD_AMT, S_XF_ACC, S_XF_CUR, S_XF_AMT, S_ERROR, S_SUCCESS, S_LOCKED
  } state_t;

  state_t         r_state, w_next;
  logic [3:0]     r_tries, w_tries_next, w_tries_dec;
  logic [TW-1:0]  r_idle_cnt;
  logic [LW-1:0]  r_lock_cnt;
  logic           r_pulse, r_s1, r_s2, r_d;
  logic           w_timeout, w_lock_exp, w_step;

  assign w_tries_dec = (r_tries == 4'd0) ? 4'd0 : r_tries - 4'd1;
  assign w_timeout   = (r_idle_cnt == T_LAST) && (r_state != S_IDLE) && (r_state != S_LOCKED);
  assign w_lock_exp  = (r_state == S_LOCKED) && (r_lock_cnt == L_LAST);
  assign w_step      = r_s2 && !r_d && (DEBUG_STEP_EN != 0);

  // Priority: expiry events, then any status, then menu (MENU only), then debug step
  always_comb begin
    w_next       = r_state;
    w_tries_next = r_tries;
    if (w_timeout) begin
      w_next = S_IDLE;
    end else if (w_lock_exp) begin
      w_next       = S_IDLE;
      w_tries_next = TRIES;
    end else if (status_valid) begin
      case (r_state)
        S_IDLE:     w_next = (status_code == C_DONE) ? S_ACC_NUM : r_state;
        S_ACC_NUM:  w_next = (status_code == C_ACC_FOUND) ? S_PIN : (status_code == C_ACC_NF) ? S_IDLE : r_state;
        S_PIN: begin
          if (status_code == C_PIN_OK) begin
            w_next       = S_MENU;
            w_tries_next = TRIES;
          end else if (status_code == C_PIN_BAD) begin
            w_tries_next = w_tries_dec;
            w_next       = (w_tries_dec == 4'd0) ? S_LOCKED : S_PIN;
          end
        end
        S_MENU:     w_next = (status_code == C_EXIT) ? S_IDLE : r_state;
        S_BAL, S_ERROR, S_SUCCESS:
                    w_next = (status_code == C_EXIT) ? S_MENU : r_state;
        S_CONV_SRC: w_next = (status_code == C_DONE) ? S_CONV_AMT : (status_code == C_EXIT) ? S_MENU : r_state;
        S_CONV_AMT: w_next = (status_code == C_AMT_OK) ? S_CONV_DST : (status_code == C_AMT_BAD) ? S_ERROR :
                             (status_code == C_EXIT) ? S_MENU : r_state;
        S_CONV_DST: w_next = (status_code == C_DONE) ? S_SUCCESS : (status_code == C_EXIT) ? S_MENU : r_state;
        S_WD_CUR:   w_next = (status_code == C_DONE) ? S_WD_AMT : (status_code == C_EXIT) ? S_MENU : r_state;
        S_WD_AMT, S_XF_AMT:
                    w_next = (status_code == C_AMT_OK) ? S_SUCCESS : (status_code == C_AMT_BAD) ? S_ERROR : r_state;
        S_XF_ACC:   w_next = (status_code == C_ACC_FOUND) ? S_XF_CUR : (status_code == C_ACC_NF) ? S_ERROR :
                             (status_code == C_EXIT) ? S_MENU : r_state;
        S_XF_CUR:   w_next = (status_code == C_DONE) ? S_XF_AMT : (status_code == C_EXIT) ? S_MENU : r_state;
        default:    w_next = r_state;
      endcase
    end else if (menu_valid && r_state == S_MENU) begin
      w_next = (menu_sel == 2'd0) ? S_BAL : (menu_sel == 2'd1) ? S_CONV_SRC :
               (menu_sel == 2'd2) ? S_WD_CUR : S_XF_ACC;
    end else if (w_step) begin
      w_next = state_t'(r_state + 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tries    <= TRIES;
      r_idle_cnt <= '0;
      r_lock_cnt <= '0;
      r_pulse    <= 1'b0;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_d        <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tries    <= w_tries_next;
      r_idle_cnt <= (status_valid || menu_valid || w_next != r_state) ? '0 :
                    (r_idle_cnt == T_LAST) ? r_idle_cnt : r_idle_cnt + 1'b1;
      r_lock_cnt <= (r_state == S_LOCKED && w_next == S_LOCKED) ? r_lock_cnt + 1'b1 : '0;
      r_pulse    <= w_timeout;
      r_s1       <= inc_state;
      r_s2       <= r_s1;
      r_d        <= r_s2;
    end
  end

  always_comb begin
    case (r_state)
      S_ACC_NUM, S_XF_ACC:                      input_style = 4'd2;
      S_PIN:                                    input_style = 4'd3;
      S_MENU:                                   input_style = 4'd4;
      S_CONV_SRC, S_CONV_DST, S_WD_CUR, S_XF_CUR: input_style = 4'd5;
      S_CONV_AMT, S_WD_AMT, S_XF_AMT:           input_style = 4'd6;
      default:                                  input_style = 4'd1;
    endcase
  end

  assign state_code     = r_state;
  assign current_state  = 16'd1 << r_state;
  assign display_mode   = (r_state == S_IDLE) ? 4'd6 : (r_state == S_LOCKED) ? 4'd1 : 4'd4;
  assign pin_tries_left = r_tries;
  assign timeout_pulse  = r_pulse;
endmodule

// File: tb/tb_atm_session_fsm.sv
// tb_atm_session_fsm: directed scenarios plus randomized traffic against a table-driven session model
module tb_atm_session_fsm;
  localparam int T = 20, L = 30, M = 3;
  logic clk = 1'b0, rst = 1'b0, status_valid = 1'b0, menu_valid = 1'b0, inc0 = 1'b0, inc1 = 1'b0;
  logic [3:0] status_code = '0;
  logic [1:0] menu_sel = '0;
  logic [3:0] sc0, is0, dm0, pt0, sc1, is1, dm1, pt1;
  logic [15:0] cs0, cs1;
  logic tp0, tp1;

  atm_session_fsm #(.TIMEOUT_CYCLES(T), .MAX_PIN_TRIES(M), .LOCK_CYCLES(L), .DEBUG_STEP_EN(1)) u0 (
    .clk(clk), .rst(rst), .status_valid(status_valid), .status_code(status_code), .menu_valid(menu_valid),
    .menu_sel(menu_sel), .inc_state(inc0), .state_code(sc0), .current_state(cs0), .input_style(is0),
    .display_mode(dm0), .pin_tries_left(pt0), .timeout_pulse(tp0));
  atm_session_fsm #(.TIMEOUT_CYCLES(T), .MAX_PIN_TRIES(M), .LOCK_CYCLES(L), .DEBUG_STEP_EN(0)) u1 (
    .clk(clk), .rst(rst), .status_valid(status_valid), .status_code(status_code), .menu_valid(menu_valid),
    .menu_sel(menu_sel), .inc_state(inc1), .state_code(sc1), .current_state(cs1), .input_style(is1),
    .display_mode(dm1), .pin_tries_left(pt1), .timeout_pulse(tp1));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int m_st, m_tries, m_idle, m_lock, m_pulse;
  bit [2:0] m_h;
  int tbl[16][16];
  int style_of[16] = '{1, 2, 3, 4, 1, 5, 6, 5, 5, 6, 2, 5, 6, 1, 1, 1};
  int menu_dst[4] = '{4, 5, 8, 10};

  // Transition table: tbl[state][code] = destination, -1 = no change
  task automatic init_tbl();
    int cancel[6] = '{5, 6, 7, 8, 10, 11};
    for (int s = 0; s < 16; s++) for (int c = 0; c < 16; c++) tbl[s][c] = -1;
    tbl[0][8] = 1;  tbl[1][1] = 2;  tbl[1][2] = 0;  tbl[3][7] = 0;
    tbl[4][7] = 3;  tbl[13][7] = 3; tbl[14][7] = 3;
    tbl[5][8] = 6;  tbl[6][5] = 7;  tbl[6][6] = 13; tbl[7][8] = 14;
    tbl[8][8] = 9;  tbl[9][5] = 14; tbl[9][6] = 13;
    tbl[10][1] = 11; tbl[10][2] = 13; tbl[11][8] = 12; tbl[12][5] = 14; tbl[12][6] = 13;
    foreach (cancel[i]) tbl[cancel[i]][7] = 3;
  endtask

  task automatic m_step(input bit r, input bit v, input int c, input bit mvv, input int sel, input bit inc);
    bit edge_d, to, le;
    int nst;
    if (r) begin
      m_st = 0; m_tries = M; m_idle = 0; m_lock = 0; m_pulse = 0; m_h = '0;
      return;
    end
    edge_d = m_h[1] && !m_h[2];
    m_h = {m_h[1:0], inc};
    to = (m_idle == T - 1) && m_st != 0 && m_st != 15;
    le = (m_st == 15) && (m_lock == L - 1);
    nst = m_st;
    if (to) nst = 0;
    else if (le) begin nst = 0; m_tries = M; end
    else if (v) begin
      if (m_st == 2 && c == 4) begin
        m_tries = (m_tries > 0) ? m_tries - 1 : 0;
        if (m_tries == 0) nst = 15;
      end else if (m_st == 2 && c == 3) begin
        nst = 3; m_tries = M;
      end else if (tbl[m_st][c] >= 0) nst = tbl[m_st][c];
    end else if (mvv && m_st == 3) nst = menu_dst[sel];
    else if (edge_d) nst = (m_st + 1) % 16;
    m_idle = (v || mvv || nst != m_st) ? 0 : ((m_idle < T - 1) ? m_idle + 1 : m_idle);
    m_lock = (m_st == 15 && nst == 15) ? m_lock + 1 : 0;
    m_pulse = to;
    m_st = nst;
  endtask

  task automatic tick(input bit r, input bit v, input int c, input bit mvv, input int sel, input bit a, input bit b);
    @(negedge clk);
    rst = r; status_valid = v; status_code = 4'(c); menu_valid = mvv; menu_sel = 2'(sel); inc0 = a; inc1 = b;
    @(posedge clk);
    m_step(r, v, c, mvv, sel, a);
    #1;
  endtask

  task automatic st(input int c);
    tick(0, 1, c, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (sc0 !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", sc0); end
    n_cmp++; if (cs0 !== 16'h0001) begin n_fail++; $display("FAIL reset_onehot got %h want 0001", cs0); end
    n_cmp++; if (is0 !== 4'd1) begin n_fail++; $display("FAIL reset_style got %0d want 1", is0); end
    n_cmp++; if (dm0 !== 4'd6) begin n_fail++; $display("FAIL reset_display got %0d want 6", dm0); end
    n_cmp++; if (pt0 !== 4'(M)) begin n_fail++; $display("FAIL reset_tries got %0d want %0d", pt0, M); end
    n_cmp++; if (tp0 !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %0d want 0", tp0); end
  endtask

  task automatic test_session();
    int codes[6] = '{8, 1, 3, -1, 8, 5};
    int want[6] = '{1, 2, 3, 8, 9, 14};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (codes[i] < 0) tick(0, 0, 0, 1, 2, 0, 0); else st(codes[i]);
      n_cmp++;
      if (sc0 !== 4'(want[i]) || sc0 !== 4'(m_st)) begin
        n_fail++; $display("FAIL session_step%0d got %0d want %0d", i, sc0, want[i]);
      end
    end
    n_cmp++; if (is0 !== 4'd1) begin n_fail++; $display("FAIL session_style got %0d want 1", is0); end
    n_cmp++; if (dm0 !== 4'd4) begin n_fail++; $display("FAIL session_display got %0d want 4", dm0); end
    st(7);
    n_cmp++; if (sc0 !== 4'd3) begin n_fail++; $display("FAIL session_exit got %0d want 3", sc0); end
    n_cmp++; if (is0 !== 4'd4) begin n_fail++; $display("FAIL session_menu_style got %0d want 4", is0); end
  endtask

  task automatic test_pin_lock();
    do_reset();
    st(8); st(1);
    for (int i = 1; i <= 2; i++) begin
      st(4);
      n_cmp++;
      if (pt0 !== 4'(M - i) || sc0 !== 4'd2) begin
        n_fail++; $display("FAIL pin_wrong%0d got tries %0d state %0d want tries %0d state 2", i, pt0, sc0, M - i);
      end
    end
    st(4);
    n_cmp++;
    if (sc0 !== 4'd15 || dm0 !== 4'd1 || pt0 !== 4'd0) begin
      n_fail++; $display("FAIL pin_lock got state %0d disp %0d tries %0d want 15 1 0", sc0, dm0, pt0);
    end
    tick(0, 1, 3, 1, 0, 0, 0);
    idle(28);
    n_cmp++; if (sc0 !== 4'd15) begin n_fail++; $display("FAIL lock_hold got %0d want 15", sc0); end
    idle(1);
    n_cmp++;
    if (sc0 !== 4'd0 || pt0 !== 4'(M)) begin
      n_fail++; $display("FAIL lock_expire got state %0d tries %0d want 0 %0d", sc0, pt0, M);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      st(8); st(1); st(3);
      if (pass == 1) begin
        idle(18);
        st(0);
      end
      pulses = 0;
      for (int i = 1; i <= 19; i++) begin
        idle(1);
        if (tp0 === 1'b1 || sc0 !== 4'd3) pulses++;
      end
      n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL timeout_early%0d got %0d early events want 0", pass, pulses); end
      idle(1);
      n_cmp++;
      if (tp0 !== 1'b1 || sc0 !== 4'd0 || pt0 !== 4'(m_tries)) begin
        n_fail++; $display("FAIL timeout_fire%0d got pulse %0d state %0d want 1 0", pass, tp0, sc0);
      end
      idle(1);
      n_cmp++; if (tp0 !== 1'b0) begin n_fail++; $display("FAIL timeout_width%0d got %0d want 0", pass, tp0); end
    end
  endtask

  task automatic test_priority();
    do_reset();
    st(8); st(1); st(3);
    tick(0, 1, 7, 1, 0, 0, 0);
    n_cmp++; if (sc0 !== 4'd0) begin n_fail++; $display("FAIL prio_status_menu got %0d want 0", sc0); end
    st(8); st(1); st(3);
    tick(0, 1, 9, 1, 1, 0, 0);
    n_cmp++; if (sc0 !== 4'(m_st)) begin n_fail++; $display("FAIL prio_ignored_code got %0d want %0d", sc0, m_st); end
  endtask

  task automatic test_debug_step();
    int changes;
    logic [3:0] prev;
    do_reset();
    st(8); st(1); st(4); st(4); st(4);
    changes = 0;
    prev = sc0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0, 0, 1, 1);
      if (sc0 !== prev) changes++;
      prev = sc0;
      n_cmp++;
      if (sc0 !== 4'((i < 2) ? 15 : 0)) begin
        n_fail++; $display("FAIL step_cycle%0d got %0d want %0d", i, sc0, (i < 2) ? 15 : 0);
      end
      n_cmp++; if (sc1 !== 4'd15) begin n_fail++; $display("FAIL step_disabled%0d got %0d want 15", i, sc1); end
    end
    idle(4);
    n_cmp++; if (changes != 1 || sc0 !== 4'd0) begin n_fail++; $display("FAIL step_count got %0d steps state %0d want 1 0", changes, sc0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    st(8); st(1); st(4); st(3); tick(0, 0, 0, 1, 3, 0, 0); st(1); st(8);
    n_cmp++; if (sc0 !== 4'd12) begin n_fail++; $display("FAIL midrst_reach got %0d want 12", sc0); end
    st(4);
    tick(1, 1, 5, 0, 0, 0, 0);
    n_cmp++;
    if (sc0 !== 4'd0 || cs0 !== 16'h0001 || pt0 !== 4'(M) || tp0 !== 1'b0) begin
      n_fail++; $display("FAIL midrst got state %0d onehot %h tries %0d want 0 0001 %0d", sc0, cs0, pt0, M);
    end
  endtask

  task automatic test_random();
    bit v, mvv, r, inc;
    int c, sel;
    logic [15:0] oh;
    inc = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit quiet;
      quiet = ((cyc / 150) % 3) == 2;
      v = $urandom_range(0, 99) < (quiet ? 2 : 40);
      c = $urandom_range(0, 9);
      mvv = $urandom_range(0, 99) < (quiet ? 1 : 20);
      sel = $urandom_range(0, 3);
      if ($urandom_range(0, 99) < 4) inc = ~inc;
      r = $urandom_range(0, 999) == 0;
      tick(r, v, c, mvv, sel, inc, 0);
      oh = 16'd1 << m_st;
      n_cmp++;
      if (sc0 !== 4'(m_st) || cs0 !== oh || is0 !== 4'(style_of[m_st]) || pt0 !== 4'(m_tries) || tp0 !== 1'(m_pulse) ||
          dm0 !== 4'((m_st == 0) ? 6 : (m_st == 15) ? 1 : 4)) begin
        n_fail++;
        $display("FAIL random_cyc%0d got st %0d oh %h sty %0d dm %0d tries %0d pulse %0d want st %0d tries %0d pulse %0d",
                 cyc, sc0, cs0, is0, dm0, pt0, tp0, m_st, m_tries, m_pulse);
      end
    end
  endtask

  initial begin
    init_tbl();
    m_step(1, 0, 0, 0, 0, 0);
    test_reset();
    test_session();
    test_pin_lock();
    test_timeout();
    test_priority();
    test_debug_step();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
